// File: rtl/mac_pkg.sv
// ============================================================================
// Module      : mac_pkg
// Description : Shared types and constants for the mac_seq multiply-
//               accumulate sequencer (state encoding, default widths).
// Revision    : 1.0 - initial release
// ============================================================================
`default_nettype none

package mac_pkg;

  // Sequencer states
  typedef enum logic [2:0] {
    S_IDLE    = 3'd0,
    S_FETCH   = 3'd1,
    S_MULT    = 3'd2,
    S_RELEASE = 3'd3,
    S_DONE    = 3'd4
  } mac_state_t;

  // Default accumulator width (must be at least PROD_W)
  localparam int ACC_W_DEF = 20;

  // Width of the signed product delivered by the multiplier
  localparam int PROD_W = 16;

endpackage : mac_pkg

`default_nettype wire

// File: rtl/mac_acc_add.sv
// ============================================================================
// Module      : mac_acc_add
// Description : Combinational accumulate step: sign-extends the 16-bit
//               product, adds it to the accumulator at ACC_W+1 bits and
//               flags signed overflow. Build option MAC_SAT_EN clamps the
//               result to the most-positive/most-negative value on overflow;
//               without it the result wraps modulo 2^ACC_W.
// Revision    : 1.0 - initial release
// ============================================================================
`default_nettype none

module mac_acc_add
  import mac_pkg::*;
#(
  parameter int ACC_W = ACC_W_DEF
) (
  input  logic [ACC_W-1:0]  acc_i,
  input  logic [PROD_W-1:0] prod_i,
  output logic [ACC_W-1:0]  sum_o,
  output logic              ovf_o
);

  logic [ACC_W:0] acc_ext;
  logic [ACC_W:0] prod_ext;
  logic [ACC_W:0] sum_ext;

  assign acc_ext  = {acc_i[ACC_W-1], acc_i};
  assign prod_ext = {{(ACC_W + 1 - PROD_W){prod_i[PROD_W-1]}}, prod_i};
  assign sum_ext  = acc_ext + prod_ext;

  // With both operands sign-extended by one bit, the top two sum bits differ
  // exactly when same-signed operands produce a result of the other sign.
  // The top bit is the true sign and therefore gives the overflow direction.
  assign ovf_o = sum_ext[ACC_W] ^ sum_ext[ACC_W-1];

`ifdef MAC_SAT_EN
  // Clamp toward the true sign of the infinite-precision sum
  always_comb begin
    sum_o = sum_ext[ACC_W-1:0];
    if (ovf_o) begin
      sum_o = sum_ext[ACC_W] ? {1'b1, {(ACC_W - 1){1'b0}}}
                             : {1'b0, {(ACC_W - 1){1'b1}}};
    end
  end
`else
  assign sum_o = sum_ext[ACC_W-1:0];
`endif

endmodule : mac_acc_add

`default_nettype wire

// File: rtl/mac_seq.sv
// ============================================================================
// Module      : mac_seq
// Description : Multiply-accumulate sequencer. Accepts signed 8-bit operand
//               pairs over valid/ready, runs each pair through an external
//               start/done multiplier and accumulates the products into a
//               signed ACC_W-bit dot product with a sticky overflow flag.
//               Build option MAC_SAT_EN selects saturating accumulation.
// Revision    : 1.0 - initial release
// ============================================================================
`default_nettype none

module mac_seq
  import mac_pkg::*;
#(
  parameter int ACC_W = ACC_W_DEF
) (
  input  logic              clk,
  input  logic              reset_L,
  input  logic              go,
  input  logic [7:0]        len,
  input  logic              in_valid,
  input  logic [7:0]        in_A,
  input  logic [7:0]        in_B,
  output logic              in_ready,
  output logic [7:0]        mult_A,
  output logic [7:0]        mult_B,
  output logic              mult_start,
  input  logic              mult_done,
  input  logic [PROD_W-1:0] mult_out,
  output logic [ACC_W-1:0]  acc,
  output logic              acc_valid,
  output logic              ovf,
  output logic              busy
);

  mac_state_t       state_q;
  logic [7:0]       cnt_q;
  logic [7:0]       mult_a_q;
  logic [7:0]       mult_b_q;
  logic [ACC_W-1:0] acc_q;
  logic             ovf_q;
  logic             in_ready_q;
  logic             mult_start_q;
  logic             acc_valid_q;
  logic             busy_q;

  logic [ACC_W-1:0] acc_d;
  logic             add_ovf;

  mac_acc_add #(
    .ACC_W (ACC_W)
  ) u_acc_add (
    .acc_i  (acc_q),
    .prod_i (mult_out),
    .sum_o  (acc_d),
    .ovf_o  (add_ovf)
  );

  // Sequencer FSM; every handshake output is registered and updated on the
  // transition into the state that owns it
  always_ff @(posedge clk or negedge reset_L) begin
    if (!reset_L) begin
      state_q      <= S_IDLE;
      cnt_q        <= 8'd0;
      mult_a_q     <= 8'd0;
      mult_b_q     <= 8'd0;
      acc_q        <= '0;
      ovf_q        <= 1'b0;
      in_ready_q   <= 1'b0;
      mult_start_q <= 1'b0;
      acc_valid_q  <= 1'b0;
      busy_q       <= 1'b0;
    end else begin
      acc_valid_q <= 1'b0;
      case (state_q)
        S_IDLE: begin
          if (go) begin
            acc_q  <= '0;
            ovf_q  <= 1'b0;
            busy_q <= 1'b1;
            if (len != 8'd0) begin
              cnt_q      <= len;
              in_ready_q <= 1'b1;
              state_q    <= S_FETCH;
            end else begin
              acc_valid_q <= 1'b1;
              state_q     <= S_DONE;
            end
          end
        end
        S_FETCH: begin
          if (in_valid && in_ready_q) begin
            mult_a_q     <= in_A;
            mult_b_q     <= in_B;
            in_ready_q   <= 1'b0;
            mult_start_q <= 1'b1;
            state_q      <= S_MULT;
          end
        end
        S_MULT: begin
          if (mult_done) begin
            acc_q        <= acc_d;
            ovf_q        <= ovf_q | add_ovf;
            cnt_q        <= cnt_q - 8'd1;
            mult_start_q <= 1'b0;
            state_q      <= S_RELEASE;
          end
        end
        S_RELEASE: begin
          // Wait for the multiplier to drop done before the next request
          if (!mult_done) begin
            if (cnt_q == 8'd0) begin
              acc_valid_q <= 1'b1;
              state_q     <= S_DONE;
            end else begin
              in_ready_q <= 1'b1;
              state_q    <= S_FETCH;
            end
          end
        end
        S_DONE: begin
          busy_q  <= 1'b0;
          state_q <= S_IDLE;
        end
        default: begin
          in_ready_q   <= 1'b0;
          mult_start_q <= 1'b0;
          busy_q       <= 1'b0;
          state_q      <= S_IDLE;
        end
      endcase
    end
  end

  assign in_ready   = in_ready_q;
  assign mult_A     = mult_a_q;
  assign mult_B     = mult_b_q;
  assign mult_start = mult_start_q;
  assign acc        = acc_q;
  assign acc_valid  = acc_valid_q;
  assign ovf        = ovf_q;
  assign busy       = busy_q;

endmodule : mac_seq

`default_nettype wire

// File: tb/tb_mac_seq.sv
// ============================================================================
// Module      : tb_mac_seq
// Description : Scoreboard bench for mac_seq with a behavioural start/done
//               signed multiplier. Expected (acc, ovf) results are queued at
//               job issue and checked on each acc_valid pulse.
//               Honours MAC_SAT_EN for the overflow expectation.
// Revision    : 1.0 - initial release
// ============================================================================
`default_nettype none

module tb_mac_seq;

  localparam int ACC_W   = 20;
  localparam int MUL_LAT = 3;

  logic             clk;
  logic             reset_L;
  logic             go;
  logic [7:0]       len;
  logic             in_valid;
  logic [7:0]       in_A;
  logic [7:0]       in_B;
  logic             in_ready;
  logic [7:0]       mult_A;
  logic [7:0]       mult_B;
  logic             mult_start;
  logic             mult_done;
  logic [15:0]      mult_out;
  logic [ACC_W-1:0] acc;
  logic             acc_valid;
  logic             ovf;
  logic             busy;

  mac_seq #(
    .ACC_W (ACC_W)
  ) dut (
    .clk        (clk),
    .reset_L    (reset_L),
    .go         (go),
    .len        (len),
    .in_valid   (in_valid),
    .in_A       (in_A),
    .in_B       (in_B),
    .in_ready   (in_ready),
    .mult_A     (mult_A),
    .mult_B     (mult_B),
    .mult_start (mult_start),
    .mult_done  (mult_done),
    .mult_out   (mult_out),
    .acc        (acc),
    .acc_valid  (acc_valid),
    .ovf        (ovf),
    .busy       (busy)
  );

  initial clk = 1'b0;
  always #5 clk = ~clk;

  // Behavioural multiplier: done rises MUL_LAT cycles after start, is held
  // while start stays high and drops once start is released
  int m_cnt;
  always @(posedge clk or negedge reset_L) begin
    if (!reset_L) begin
      mult_done <= 1'b0;
      mult_out  <= 16'd0;
      m_cnt     <= 0;
    end else if (!mult_start) begin
      mult_done <= 1'b0;
      m_cnt     <= 0;
    end else if (!mult_done) begin
      if (m_cnt == MUL_LAT - 1) begin
        mult_done <= 1'b1;
        mult_out  <= $signed(mult_A) * $signed(mult_B);
      end else begin
        m_cnt <= m_cnt + 1;
      end
    end
  end

  // Bookkeeping
  int n_chk = 0;
  int n_err = 0;
  int cyc = 0;
  int jobs_done = 0;
  int valid_cyc = 0;
  int ready_cnt = 0;
  int start_cnt = 0;
  bit overlap_seen = 1'b0;

  typedef struct {
    logic [ACC_W-1:0] acc;
    logic             ovf;
  } exp_t;
  exp_t exp_q[$];

  logic [7:0] va[64];
  logic [7:0] vb[64];

  task automatic chk(input string name, input logic [31:0] act, input logic [31:0] want);
    n_chk++;
    if (act !== want) begin
      n_err++;
      $display("FAIL %s: got 0x%0h expected 0x%0h", name, act, want);
    end
  endtask

  initial forever begin
    @(posedge clk);
    cyc++;
  end

  // Monitor: compares every completed job against the scoreboard
  initial forever begin
    @(negedge clk);
    if (reset_L) begin
      if (in_ready && mult_start) overlap_seen = 1'b1;
      if (in_ready) ready_cnt++;
      if (mult_start) start_cnt++;
      if (acc_valid) begin
        valid_cyc = cyc;
        if (exp_q.size() == 0) begin
          n_chk++;
          n_err++;
          $display("FAIL unexpected_acc_valid: got acc=0x%0h with no job pending", acc);
        end else begin
          exp_t e;
          e = exp_q.pop_front();
          chk("acc", 32'(acc), 32'(e.acc));
          chk("ovf", 32'(ovf), 32'(e.ovf));
        end
        jobs_done++;
      end
    end
  end

  task automatic pulse_go(input logic [7:0] l);
    @(negedge clk);
    go  = 1'b1;
    len = l;
    @(negedge clk);
    go  = 1'b0;
  endtask

  task automatic send_pair(input logic [7:0] a, input logic [7:0] b, input int gap);
    int t;
    repeat (gap) @(negedge clk);
    in_valid = 1'b1;
    in_A     = a;
    in_B     = b;
    t = 0;
    while (!in_ready && t < 200) begin
      @(negedge clk);
      t++;
    end
    if (!in_ready) begin
      n_chk++;
      n_err++;
      $display("FAIL in_ready_timeout: got 0 expected 1");
    end
    @(negedge clk);
    in_valid = 1'b0;
  endtask

  task automatic wait_jobs(input int target);
    int t;
    t = 0;
    while (jobs_done < target && t < 2000) begin
      @(negedge clk);
      t++;
    end
    if (jobs_done < target) begin
      n_chk++;
      n_err++;
      $display("FAIL job_timeout: got %0d jobs expected %0d", jobs_done, target);
    end
  endtask

  task automatic run_job(input int n, input int gap, input bit poke_go,
                         input logic [ACC_W-1:0] e_acc, input logic e_ovf);
    exp_t e;
    int   target;
    e.acc = e_acc;
    e.ovf = e_ovf;
    exp_q.push_back(e);
    target = jobs_done + 1;
    pulse_go(8'(n));
    for (int i = 0; i < n; i++) begin
      send_pair(va[i], vb[i], gap);
      if (poke_go && i == 0) pulse_go(8'd1);
    end
    wait_jobs(target);
    repeat (3) @(negedge clk);
    chk("acc_hold", 32'(acc), 32'(e_acc));
  endtask

  task automatic load4(input logic [7:0] a0, input logic [7:0] b0, input logic [7:0] a1,
                       input logic [7:0] b1, input logic [7:0] a2, input logic [7:0] b2,
                       input logic [7:0] a3, input logic [7:0] b3);
    va[0] = a0; vb[0] = b0; va[1] = a1; vb[1] = b1;
    va[2] = a2; vb[2] = b2; va[3] = a3; vb[3] = b3;
  endtask

  task automatic check_all_zero(input string tag);
    chk({tag, "_acc"}, 32'(acc), 32'd0);
    chk({tag, "_ovf"}, 32'(ovf), 32'd0);
    chk({tag, "_busy"}, 32'(busy), 32'd0);
    chk({tag, "_in_ready"}, 32'(in_ready), 32'd0);
    chk({tag, "_mult_start"}, 32'(mult_start), 32'd0);
    chk({tag, "_acc_valid"}, 32'(acc_valid), 32'd0);
    chk({tag, "_mult_A"}, 32'(mult_A), 32'd0);
    chk({tag, "_mult_B"}, 32'(mult_B), 32'd0);
  endtask

  initial begin
    #1_000_000;
    $display("FAIL watchdog: simulation time limit reached");
    $fatal(1, "watchdog");
  end

  initial begin
    int t;
    int go_cyc;
    int r0;
    int s0;
    logic [ACC_W-1:0] e_big;

    reset_L  = 1'b0;
    go       = 1'b0;
    len      = 8'd0;
    in_valid = 1'b0;
    in_A     = 8'd0;
    in_B     = 8'd0;
    repeat (3) @(negedge clk);
    check_all_zero("reset");
    reset_L = 1'b1;
    repeat (2) @(negedge clk);

    // Single pair: -128 * -1 = 128
    va[0] = 8'h80; vb[0] = 8'hFF;
    run_job(1, 0, 1'b0, 20'h00080, 1'b0);

    // Three pairs: 12 - 10 + 16129 = 16131
    load4(8'd3, 8'd4, 8'hFE, 8'd5, 8'h7F, 8'h7F, 8'd0, 8'd0);
    run_job(3, 0, 1'b0, 20'h03F03, 1'b0);

    // Zero length: no operand traffic, quick acc_valid, acc cleared
    r0 = ready_cnt;
    s0 = start_cnt;
    begin
      exp_t e;
      e.acc = '0;
      e.ovf = 1'b0;
      exp_q.push_back(e);
    end
    t = jobs_done + 1;
    @(negedge clk);
    go     = 1'b1;
    len    = 8'd0;
    go_cyc = cyc;
    @(negedge clk);
    go = 1'b0;
    wait_jobs(t);
    chk("len0_latency_ok", 32'((valid_cyc - go_cyc >= 1) && (valid_cyc - go_cyc <= 2)), 32'd1);
    chk("len0_in_ready_cycles", 32'(ready_cnt - r0), 32'd0);
    chk("len0_mult_start_cycles", 32'(start_cnt - s0), 32'd0);
    repeat (2) @(negedge clk);

    // Overflow: 32 x 16384 = 2^19 exceeds the 20-bit signed range
    for (int i = 0; i < 32; i++) begin
      va[i] = 8'h80;
      vb[i] = 8'h80;
    end
`ifdef MAC_SAT_EN
    e_big = 20'h7FFFF;
`else
    e_big = 20'h80000;
`endif
    run_job(32, 0, 1'b0, e_big, 1'b1);

    // Four pairs gap-free then with 3-cycle gaps and a stray go: 16131 - 256
    load4(8'd3, 8'd4, 8'hFE, 8'd5, 8'h7F, 8'h7F, 8'h10, 8'hF0);
    run_job(4, 0, 1'b0, 20'h03E03, 1'b0);
    run_job(4, 3, 1'b1, 20'h03E03, 1'b0);

    // Reset while the multiplier is working
    pulse_go(8'd2);
    va[0] = 8'd7; vb[0] = 8'd9;
    @(negedge clk);
    in_valid = 1'b1;
    in_A     = va[0];
    in_B     = vb[0];
    t = 0;
    while (!mult_start && t < 200) begin
      @(negedge clk);
      t++;
    end
    in_valid = 1'b0;
    chk("reached_mult", 32'(mult_start), 32'd1);
    #2;
    reset_L = 1'b0;
    #1;
    check_all_zero("midreset");
    @(negedge clk);
    reset_L = 1'b1;
    repeat (2) @(negedge clk);
    chk("post_reset_busy", 32'(busy), 32'd0);

    va[0] = 8'h80; vb[0] = 8'hFF;
    run_job(1, 0, 1'b0, 20'h00080, 1'b0);

    chk("in_ready_during_mult", 32'(overlap_seen), 32'd0);
    chk("scoreboard_empty", 32'(exp_q.size()), 32'd0);

    $display("Result: errors=%0d of %0d checks", n_err, n_chk);
    $finish;
  end

endmodule : tb_mac_seq

`default_nettype wire
